// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the CPU UART read path.
// Define UART_RX_FIFO_IRQ_EN to build the registered rx_irq level interrupt.
module uart_rx_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IRQ_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       pop,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       rx_irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Reject parameter sets the pointer/counter arithmetic cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (IRQ_LEVEL < 1) || (IRQ_LEVEL > DEPTH)) begin : g_bad_cfg
    $error("uart_rx_fifo: illegal DEPTH/IRQ_LEVEL combination");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;
  logic             do_pop;

  assign in_ready  = ~rst & (cnt_q != CNT_W'(DEPTH));
  assign push      = in_valid & in_ready;
  assign do_pop    = pop & ~stall & (cnt_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (cnt_q != '0);
  assign level     = cnt_q;

  // Pointers wrap naturally; full and empty are told apart by cnt alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; cnt gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic rx_irq_q, rx_irq_d;

  assign rx_irq_d = (cnt_d >= CNT_W'(IRQ_LEVEL));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_irq_q <= 1'b0;
    end else begin
      rx_irq_q <= rx_irq_d;
    end
  end

  assign rx_irq = rx_irq_q;
`else
  assign rx_irq = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the MIPS150 datapath's UART read path. It accepts bytes from the UART on a ready/valid handshake and holds up to DEPTH bytes. The CPU pops one byte per UART-data load, so no receive traffic is lost while the pipeline is stalled on the memory system. It also reports the fill level for the UART status read and, optionally, a level interrupt.

## Interface
Parameters:
- DEPTH, 8: entry count; power of two, ≥ 2.
- WIDTH, 8: data width in bits.
- IRQ_LEVEL, 4: fill threshold for rx_irq; 1 ≤ IRQ_LEVEL ≤ DEPTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- stall  input  1  memory-system stall; when high, CPU pops are ignored.
- in_data  input  WIDTH  byte from UART receiver (UART DataOut).
- in_valid  input  1  in_data valid (UART DataOutValid).
- in_ready  output  1  FIFO can accept (drives UART DataOutReady).
- pop  input  1  CPU consumes the head byte (UART data load, REUART).
- out_data  output  WIDTH  head byte; valid only while out_valid.
- out_valid  output  1  FIFO non-empty (UART status "data available" bit).
- level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- rx_irq  output  1  level interrupt (see Configuration).

## Operation
- Storage: DEPTH×WIDTH array, write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits each, natural wrap), occupancy counter cnt.
- push = in_valid & in_ready; in_ready = ~rst & (cnt != DEPTH).
- do_pop = pop & ~stall & (cnt != 0).
- push only: mem[wr_ptr] ← in_data, wr_ptr+1, cnt+1.
- do_pop only: rd_ptr+1, cnt−1.
- push & do_pop on the same cycle: both pointers advance, cnt unchanged. Legal at any 0 < cnt < DEPTH.
- Full (cnt = DEPTH): in_ready low, so push is impossible. A pop that cycle frees one slot, and in_ready rises the next cycle.
- Empty (cnt = 0): pop is ignored, and out_data is don't-care. A push that cycle still lands, and the byte is visible next cycle.
- pop while stall = 1: ignored; head byte, pointers, and cnt are held. The CPU re-issues the pop after the stall.
- Pointer wrap: wr_ptr/rd_ptr roll DEPTH−1 → 0 with no special handling. Full and empty are distinguished by cnt only.
- out_data = mem[rd_ptr] (combinational array read). out_valid = (cnt != 0). level = cnt.
- rst mid-operation: contents discarded, and pointers and cnt cleared the same edge. A byte offered by the UART in the reset cycle is not accepted, because in_ready is low.

## Timing
- Reset values: in_ready 0 while rst is high, 1 on the first cycle after. out_valid 0, level 0, rx_irq 0. out_data is undefined.
- Write-to-read latency: a byte pushed at edge N appears on out_data/out_valid after edge N (cycle N+1).
- Pop effect: a pop sampled at edge N presents the next byte (or out_valid = 0) after edge N.
- in_ready and out_valid depend only on registered state, plus rst for in_ready. There is no combinational path from pop or in_valid.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- Macro: UART_RX_FIFO_IRQ_EN.
- Defined: rx_irq is a register, set to (cnt_next ≥ IRQ_LEVEL) each edge, so it reflects the post-update level one cycle after the push or pop. Reset value 0.
- Undefined: rx_irq is tied to 0, no threshold logic is synthesized, and IRQ_LEVEL is unused. The port is present in both builds.

## Test plan
- Reset/fill: assert rst 2 cycles, then push 0x41..0x48 (8 bytes, DEPTH = 8). After the 8th edge: level = 8, in_ready = 0. A 9th in_valid with 0x49 is not accepted.
- Drain order with wrap: from the full state, pop 3 (0x41, 0x42, 0x43 out). Push 0x50, 0x51, 0x52, which wraps wr_ptr. Pop all 8; the sequence must be 0x44..0x48, 0x50..0x52, then out_valid = 0 and level = 0.
- Simultaneous push/pop: with level = 3, hold push and pop for 10 cycles. level stays 3 and output order matches input order.
- Stall: with level = 2 and head 0x10, assert pop with stall = 1 for 4 cycles. out_data stays 0x10 and level stays 2. Deassert stall with pop = 1: the next cycle shows the second byte and level = 1.
- Empty corner: at level 0, drive in_valid = 1 (0x7E) and pop = 1 on the same cycle. The next cycle shows out_valid = 1, out_data = 0x7E, level = 1.
- Reset mid-operation and IRQ: with UART_RX_FIFO_IRQ_EN and IRQ_LEVEL = 4, push 4 bytes; rx_irq rises the cycle after the 4th push. Pop 1: rx_irq falls the next cycle. Assert rst at level 5: the next cycle shows level 0, out_valid 0, rx_irq 0, in_ready 0. Without the macro, rx_irq stays 0 throughout.
